lzc_norm_pipe: RTL and testbench



---
 rtl/lzc_norm_pipe.sv | 122 ++++++++++++
 tb/tb_lzc_norm_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero / leading-sign counter with normalising left shift.
// Stage 1 forms per-nibble counts; stage 2 priority-encodes them and shifts.
module lzc_norm_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG = WIDTH / 4;

    // Handshake: a word moves on valid && ready; held stages keep all data stable.
    logic             s1_v;
    logic             s2_v;
    logic             s2_en;
    logic             s1_adv;
    logic             in_fire;

    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [NG-1:0][1:0] s1_cnt;
    logic [NG-1:0]    s1_zero;

    assign s2_en     = !s2_v || out_ready;
    assign s1_adv    = s1_v && s2_en && !flush;
    assign in_ready  = !flush && (!s1_v || s2_en);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_v;

    // CLS counts leading zeros of the sign-xored lower bits; the appended 1
    // caps the count at WIDTH-1 when every lower bit matches the sign.
    logic [WIDTH-1:0]   scan;
    logic [NG-1:0][1:0] nib_cnt;
    logic [NG-1:0]      nib_zero;

    always_comb begin
        scan     = in_data;
        nib_cnt  = '0;
        nib_zero = '0;
        if (in_mode) begin
            scan = {in_data[WIDTH-2:0] ^ {(WIDTH-1){in_data[WIDTH-1]}}, 1'b1};
        end
        for (int g = 0; g < NG; g++) begin
            nib_zero[g] = (scan[4*g +: 4] == 4'b0000);
            if (scan[4*g+3])      nib_cnt[g] = 2'd0;
            else if (scan[4*g+2]) nib_cnt[g] = 2'd1;
            else if (scan[4*g+1]) nib_cnt[g] = 2'd2;
            else                  nib_cnt[g] = 2'd3;
        end
    end

    logic             found;
    logic [CW-1:0]    cnt_c;
    logic             zero_c;
    logic [WIDTH-1:0] norm_c;

    always_comb begin
        found = 1'b0;
        cnt_c = CW'(WIDTH);
        for (int g = NG - 1; g >= 0; g--) begin
            if (!found && !s1_zero[g]) begin
                found = 1'b1;
                cnt_c = CW'(4 * (NG - 1 - g)) + CW'(s1_cnt[g]);
            end
        end
        zero_c = s1_mode ? (cnt_c == CW'(WIDTH - 1)) : !found;
        norm_c = s1_data << cnt_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= 1'b0;
            s1_tag    <= '0;
            s1_cnt    <= '0;
            s1_zero   <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (in_ready) s1_v <= in_valid;
                if (s2_en)    s2_v <= s1_v;
            end
            if (in_fire) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_tag  <= in_tag;
                s1_cnt  <= nib_cnt;
                s1_zero <= nib_zero;
            end
            if (s1_adv) begin
                out_count <= cnt_c;
                out_zero  <= zero_c;
                out_norm  <= norm_c;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe at WIDTH=32: directed tables, backpressure, flush,
// asynchronous reset and a randomised sweep checked by an expected queue.
module tb_lzc_norm_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int CW = $clog2(W) + 1;
    localparam int EW = CW + 1 + W + TW;
    localparam int NT = 10;

    localparam logic [W-1:0]  TD [NT] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0001,
        32'h0000_0000, 32'h4000_0000, 32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFF_FFFF,
        32'h0000_0000, 32'h4000_0000};
    localparam logic          TM [NT] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    localparam int            TC [NT] = '{15, 0, 31, 32, 1, 16, 16, 31, 31, 0};
    localparam logic          TZ [NT] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
    localparam logic [W-1:0]  TN [NT] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
        32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000,
        32'h0000_0000, 32'h4000_0000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_count;
    logic          out_zero;
    logic [W-1:0]  out_norm;
    logic [TW-1:0] out_tag;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    logic [EW-1:0] exp_q[$];
    logic [TW-1:0] got_tags[$];

    lzc_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] model(input logic [W-1:0] d, input logic m,
                                            input logic [TW-1:0] t);
        int c;
        logic z;
        logic [W-1:0] n;
        if (!m) begin
            c = W;
            for (int i = 0; i < W; i++) if (d[i]) c = W - 1 - i;
            z = (d == '0);
        end else begin
            c = W - 1;
            for (int i = 0; i < W - 1; i++) if (d[i] != d[W-1]) c = W - 2 - i;
            z = (d == '0) || (d == '1);
        end
        n = d << c;
        return {CW'(c), z, n, t};
    endfunction

    // Scoreboard: expected results queued on input accept, compared on output accept.
    logic          held = 1'b0;
    logic [EW:0]   prev_out;
    logic          exp_rdy;
    logic [EW-1:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            exp_rdy = !flush && !(exp_q.size() == 2 && !out_ready);
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL in_ready got=%b required=%b occupancy=%0d", in_ready, exp_rdy, exp_q.size());
            end
            if (held) begin
                n_vec++;
                if ({out_valid, out_count, out_zero, out_norm, out_tag} !== prev_out) begin
                    n_err++;
                    $display("FAIL held_stable got=%h required=%h",
                             {out_valid, out_count, out_zero, out_norm, out_tag}, prev_out);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_vec++;
                    n_out++;
                    got_tags.push_back(out_tag);
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output tag=%0d got=valid required=none", out_tag);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if ({out_count, out_zero, out_norm, out_tag} !== exp_v) begin
                            n_err++;
                            $display("FAIL scoreboard got cnt=%0d z=%b norm=%h tag=%0d required cnt=%0d z=%b norm=%h tag=%0d",
                                     out_count, out_zero, out_norm, out_tag,
                                     exp_v[EW-1 -: CW], exp_v[W+TW], exp_v[TW +: W], exp_v[TW-1:0]);
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode, in_tag));
            end
            held = out_valid && !out_ready && !flush;
            prev_out = {out_valid, out_count, out_zero, out_norm, out_tag};
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout tag=%0d in_ready=%b required=1", t, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec += 6;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        if (out_count !== '0)   begin n_err++; $display("FAIL reset_count got=%0d required=0", out_count); end
        if (out_zero !== 1'b0)  begin n_err++; $display("FAIL reset_zero got=%b required=0", out_zero); end
        if (out_norm !== '0)    begin n_err++; $display("FAIL reset_norm got=%h required=0", out_norm); end
        if (out_tag !== '0)     begin n_err++; $display("FAIL reset_tag got=%0d required=0", out_tag); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_table();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            send(TD[i], TM[i], TW'(i));
            idle();
            lat = 0;
            while (!out_valid && lat < 4) begin
                @(negedge clk);
                lat++;
            end
            n_vec += 5;
            if (lat != 2) begin n_err++; $display("FAIL latency[%0d] got=%0d required=2", i, lat); end
            if (out_count !== CW'(TC[i])) begin n_err++; $display("FAIL count[%0d] got=%0d required=%0d", i, out_count, TC[i]); end
            if (out_zero !== TZ[i]) begin n_err++; $display("FAIL zero[%0d] got=%b required=%b", i, out_zero, TZ[i]); end
            if (out_norm !== TN[i]) begin n_err++; $display("FAIL norm[%0d] got=%h required=%h", i, out_norm, TN[i]); end
            if (out_tag !== TW'(i)) begin n_err++; $display("FAIL tag[%0d] got=%0d required=%0d", i, out_tag, i); end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_backpressure();
        got_tags.delete();
        out_ready = 1'b1;
        fork
            begin
                for (int t = 1; t <= 5; t++) send($urandom, 1'($urandom_range(0, 1)), TW'(t));
                idle();
            end
            begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        n_vec += 2;
        if (got_tags.size() != 5) begin
            n_err++;
            $display("FAIL bp_count got=%0d required=5", got_tags.size());
        end else begin
            for (int t = 0; t < 5; t++) begin
                if (got_tags[t] !== TW'(t + 1)) begin
                    n_err++;
                    $display("FAIL bp_order[%0d] got=%0d required=%0d", t, got_tags[t], t + 1);
                end
            end
        end
    endtask

    task automatic test_flush_reset();
        int base;
        out_ready = 1'b1;
        send(32'h0000_1234, 1'b0, 4'd1);
        send(32'hF000_0000, 1'b1, 4'd2);
        idle();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got=%b required=0", out_valid); end
        base = n_out;
        got_tags.delete();
        send(32'h00FF_0000, 1'b0, 4'd7);
        idle();
        drain();
        repeat (3) @(posedge clk);
        #1;
        n_vec += 2;
        if (n_out - base != 1) begin n_err++; $display("FAIL flush_outputs got=%0d required=1", n_out - base); end
        if (got_tags.size() == 0 || got_tags[0] !== 4'd7) begin
            n_err++;
            $display("FAIL flush_tag got_count=%0d required tag 7", got_tags.size());
        end
        send(32'h0000_00F0, 1'b0, 4'd8);
        send(32'h0000_0F00, 1'b1, 4'd9);
        idle();
        #2;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid got=%b required=1", out_valid); end
        rst = 1'b1;
        #1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid got=%b required=0", out_valid); end
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL async_reset_ready got=%b required=1", in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        base = n_out;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || n_out != base) begin
            n_err++;
            $display("FAIL reset_discard out_valid=%b outputs=%0d required 0", out_valid, n_out - base);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int count);
        logic done;
        logic [W-1:0] d;
        int sh;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < count; i++) begin
                    d  = $urandom;
                    sh = $urandom_range(0, W);
                    d  = (sh == W) ? '0 : (d >> sh);
                    if ($urandom_range(0, 1) == 1) d = ~d;
                    send(d, 1'($urandom_range(0, 1)), TW'($urandom));
                    if ($urandom_range(0, 7) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_table();
        test_backpressure();
        test_flush_reset();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
